// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and load/store.
// Data wins ties; a streak counter forces a fetch grant after STREAK_MAX back-to-back data wins.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_src
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StDone   = 2'd2;

    localparam logic [3:0] StreakLim = 4'(STREAK_MAX);

    logic [1:0]        state_q, state_d;
    logic [3:0]        streak_q, streak_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              grant_q, grant_d;
    logic              data_win;

    // Data takes the port unless fetch is waiting and the streak budget is spent.
    assign data_win = d_req && (!if_req || (streak_q < StreakLim));

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_d     = grant_q;
        case (state_q)
            StIdle: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                if (if_req || d_req) begin
                    state_d  = StAccess;
                    mem_en_d = 1'b1;
                    grant_d  = data_win;
                    if (data_win) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        streak_d    = if_req ? streak_q + 4'd1 : 4'd0;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        streak_d    = 4'd0;
                    end
                end
            end
            StAccess: begin
                state_d  = StDone;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d  = StIdle;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            streak_q    <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            grant_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            grant_q     <= grant_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant_src = grant_q;
    assign busy      = (state_q == StAccess) || (state_q == StDone);
    assign if_ack    = (state_q == StDone) && !grant_q;
    assign d_ack     = (state_q == StDone) && grant_q;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a cycle-budget transaction model and a reference memory image.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STREAK_MAX = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              grant_src;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STREAK_MAX(STREAK_MAX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .grant_src(grant_src)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM with a bench-side preload port.
    logic [DATA_W-1:0] ram [0:1023];
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [DATA_W-1:0] pre_data = '0;
    logic [DATA_W-1:0] ref_mem [0:15];

    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_mem();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < 16; i++) begin
            v = (i == 5) ? 32'hE3A0_1001 : 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            ref_mem[i] = v;
            pre_we = 1'b1;
            pre_addr = ADDR_W'(i);
            pre_data = v;
            tick();
        end
        pre_we = 1'b0;
    endtask

    task automatic do_reset();
        if_req = 1'b0;
        d_req = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        if_req = 1'b1;
        if_addr = 10'h3FF;
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 10'h2AA;
        d_wdata = 32'hFFFF_FFFF;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, grant_src, if_ack, d_ack, busy} !== '0)
            $display("FAIL reset_state: got en=%b we=%b a=%h wd=%h g=%b ia=%b da=%b busy=%b required all 0",
                     mem_en, mem_we, mem_addr, mem_wdata, grant_src, if_ack, d_ack, busy);
        if ({mem_en, mem_we, mem_addr, mem_wdata, grant_src, if_ack, d_ack, busy} !== '0) errors++;
        reset = 1'b0;
        if_req = 1'b0;
        d_req = 1'b0;
        tick();
        checks++;
        if ({mem_en, busy, if_ack, d_ack} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: got en/busy/ia/da=%b required 0000", {mem_en, busy, if_ack, d_ack});
        end
    endtask

    task automatic test_fetch_only();
        do_reset();
        if_req = 1'b1;
        if_addr = 10'h005;
        tick();
        checks++;
        if ({mem_en, mem_we, mem_addr, busy, if_ack} !== {1'b1, 1'b0, 10'h005, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fetch_access: got en=%b we=%b addr=%h busy=%b ack=%b required 1 0 005 1 0",
                     mem_en, mem_we, mem_addr, busy, if_ack);
        end
        tick();
        checks++;
        if ({if_ack, d_ack, if_rdata} !== {2'b10, 32'hE3A0_1001}) begin
            errors++;
            $display("FAIL fetch_ack: got ia=%b da=%b rdata=%h required 1 0 e3a01001",
                     if_ack, d_ack, if_rdata);
        end
        if_req = 1'b0;
        tick();
        checks++;
        if ({if_ack, d_ack, busy, mem_en} !== 4'b0000) begin
            errors++;
            $display("FAIL fetch_after: got ia/da/busy/en=%b required 0000", {if_ack, d_ack, busy, mem_en});
        end
    endtask

    task automatic test_write_read();
        do_reset();
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 10'h010;
        d_wdata = 32'hDEAD_BEEF;
        tick();
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, grant_src} !== {2'b11, 10'h010, 32'hDEAD_BEEF, 1'b1}) begin
            errors++;
            $display("FAIL write_access: got en=%b we=%b a=%h wd=%h g=%b required 1 1 010 deadbeef 1",
                     mem_en, mem_we, mem_addr, mem_wdata, grant_src);
        end
        tick();
        checks++;
        if ({mem_we, d_ack, if_ack} !== 3'b010) begin
            errors++;
            $display("FAIL write_ack: got we/da/ia=%b required 010", {mem_we, d_ack, if_ack});
        end
        d_we = 1'b0;
        tick();
        checks++;
        if ({busy, d_ack, mem_en} !== 3'b000) begin
            errors++;
            $display("FAIL write_idle: got busy/da/en=%b required 000", {busy, d_ack, mem_en});
        end
        tick();
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {2'b10, 10'h010}) begin
            errors++;
            $display("FAIL read_access: got en=%b we=%b a=%h required 1 0 010", mem_en, mem_we, mem_addr);
        end
        tick();
        checks++;
        if ({d_ack, d_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL read_back: got da=%b rdata=%h required 1 deadbeef", d_ack, d_rdata);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        if_req = 1'b1;
        if_addr = 10'h001;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 10'h002;
        tick();
        checks++;
        if ({grant_src, mem_addr} !== {1'b1, 10'h002}) begin
            errors++;
            $display("FAIL sim_first_grant: got g=%b a=%h required 1 002", grant_src, mem_addr);
        end
        tick();
        checks++;
        if ({d_ack, if_ack, d_rdata} !== {2'b10, ref_mem[2]}) begin
            errors++;
            $display("FAIL sim_d_ack: got da=%b ia=%b rd=%h required 1 0 %h", d_ack, if_ack, d_rdata, ref_mem[2]);
        end
        d_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({grant_src, mem_en, mem_addr} !== {2'b01, 10'h001}) begin
            errors++;
            $display("FAIL sim_second_grant: got g=%b en=%b a=%h required 0 1 001", grant_src, mem_en, mem_addr);
        end
        tick();
        checks++;
        if ({if_ack, d_ack, if_rdata} !== {2'b10, ref_mem[1]}) begin
            errors++;
            $display("FAIL sim_if_ack: got ia=%b da=%b rd=%h required 1 0 %h", if_ack, d_ack, if_rdata, ref_mem[1]);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        int k = 0;
        int cyc = 0;
        int last = -1;
        bit exp_fetch;
        logic [DATA_W-1:0] got;
        do_reset();
        if_req = 1'b1;
        if_addr = 10'h007;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 10'h003;
        while (k < 15 && cyc < 100) begin
            tick();
            cyc++;
            if (if_ack || d_ack) begin
                exp_fetch = (k % (STREAK_MAX + 1)) == STREAK_MAX;
                got = exp_fetch ? if_rdata : d_rdata;
                checks++;
                if ({if_ack, d_ack, got} !== {exp_fetch, !exp_fetch, exp_fetch ? ref_mem[7] : ref_mem[3]}) begin
                    errors++;
                    $display("FAIL starve_order: ack #%0d got ia=%b da=%b rd=%h required fetch=%b",
                             k, if_ack, d_ack, got, exp_fetch);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 3) begin
                        errors++;
                        $display("FAIL starve_spacing: got %0d cycles required 3", cyc - last);
                    end
                end
                last = cyc;
                k++;
            end
        end
        checks++;
        if (k != 15) begin
            errors++;
            $display("FAIL starve_count: got %0d acks required 15", k);
        end
        if_req = 1'b0;
        d_req = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 10'h020;
        d_wdata = 32'h1234_5678;
        tick();
        checks++;
        if ({mem_en, mem_we} !== 2'b11) begin
            errors++;
            $display("FAIL rst_mid_access: got en/we=%b required 11", {mem_en, mem_we});
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({mem_en, busy, d_ack, if_ack} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_abort: got en/busy/da/ia=%b required 0000", {mem_en, busy, d_ack, if_ack});
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({mem_en, busy, d_ack} !== 3'b110) begin
            errors++;
            $display("FAIL rst_mid_reissue: got en/busy/da=%b required 110", {mem_en, busy, d_ack});
        end
        tick();
        checks++;
        if ({d_ack, if_ack} !== 2'b10) begin
            errors++;
            $display("FAIL rst_mid_ack: got da/ia=%b required 10", {d_ack, if_ack});
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        do_reset();
        if_req = 1'b1;
        if_addr = 10'h000;
        for (int c = 1; c <= 10; c++) begin
            tick();
            checks++;
            if ({busy, if_ack, d_ack} !== {(c % 3) != 0 && c < 9, (c % 3) == 2 && c < 9, 1'b0}) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got busy/ia/da=%b", c, {busy, if_ack, d_ack});
            end
            if (if_ack) begin
                checks++;
                if (if_rdata !== ref_mem[n]) begin
                    errors++;
                    $display("FAIL b2b_rdata%0d: got %h required %h", n, if_rdata, ref_mem[n]);
                end
                n++;
                if (n == 3) if_req = 1'b0;
                else if_addr = ADDR_W'(n);
            end
        end
    endtask

    task automatic new_fetch(input bit en);
        if_req = en;
        if_addr = ADDR_W'($urandom_range(0, 15));
    endtask

    task automatic new_data(input bit en);
        d_req = en;
        d_we = 1'($urandom_range(0, 1));
        d_addr = ADDR_W'($urandom_range(0, 15));
        d_wdata = $urandom;
    endtask

    // Transaction model: a grant can only start once the previous 3-cycle slot has elapsed.
    task automatic test_random();
        int pc = -10;
        int next_free = 0;
        int data_run = 0;
        bit pv = 0;
        bit p_src, p_we, dw, in_acc, in_done;
        logic [ADDR_W-1:0] p_addr;
        logic [DATA_W-1:0] p_wdata, p_rdata, rd;
        do_reset();
        for (int cyc = 0; cyc < 900; cyc++) begin
            in_acc = pv && (cyc == pc + 1);
            in_done = pv && (cyc == pc + 2);
            checks++;
            if ({busy, mem_en, if_ack, d_ack} !== {in_acc || in_done, in_acc, in_done && !p_src, in_done && p_src}) begin
                errors++;
                $display("FAIL rand_ctrl@%0d: got busy/en/ia/da=%b required %b", cyc,
                         {busy, mem_en, if_ack, d_ack}, {in_acc || in_done, in_acc, in_done && !p_src, in_done && p_src});
            end
            if (in_acc) begin
                checks++;
                if ({mem_we, mem_addr, mem_wdata, grant_src} !== {p_we, p_addr, p_wdata, p_src}) begin
                    errors++;
                    $display("FAIL rand_access@%0d: got we=%b a=%h wd=%h g=%b required %b %h %h %b", cyc,
                             mem_we, mem_addr, mem_wdata, grant_src, p_we, p_addr, p_wdata, p_src);
                end
            end
            if (in_done && !p_we) begin
                rd = p_src ? d_rdata : if_rdata;
                checks++;
                if (rd !== p_rdata) begin
                    errors++;
                    $display("FAIL rand_rdata@%0d: got %h required %h", cyc, rd, p_rdata);
                end
            end
            if (in_done) begin
                if (p_src) new_data(1'($urandom_range(0, 1)));
                else new_fetch(1'($urandom_range(0, 1)));
            end
            if (!if_req && $urandom_range(0, 2) == 0) new_fetch(1'b1);
            if (!d_req && $urandom_range(0, 2) == 0) new_data(1'b1);
            if (cyc >= next_free && (if_req || d_req)) begin
                dw = d_req && (!if_req || data_run < int'(STREAK_MAX));
                data_run = (dw && if_req) ? data_run + 1 : 0;
                p_src = dw;
                p_we = dw && d_we;
                p_addr = dw ? d_addr : if_addr;
                p_wdata = dw ? d_wdata : '0;
                p_rdata = ref_mem[p_addr[3:0]];
                if (p_we) ref_mem[p_addr[3:0]] = d_wdata;
                pv = 1'b1;
                pc = cyc;
                next_free = cyc + 3;
            end
            tick();
        end
        if_req = 1'b0;
        d_req = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        if_req = 1'b0;
        if_addr = '0;
        d_req = 1'b0;
        d_we = 1'b0;
        d_addr = '0;
        d_wdata = '0;
        init_mem();
        test_reset();
        test_fetch_only();
        test_write_read();
        test_simultaneous();
        test_starvation();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
